// File: rtl/simd_mem_pkg.sv
// Shared types and limits for the SIMD data-memory arbiter.
//   MAX_CH / MAX_RD_LAT : supported upper bounds for channel count and RAM latency
//   ch_id_w()           : channel-index width for n channels (at least 1 bit)
//   CH_ID_W             : index width sized for MAX_CH, used for every channel tag
//   rd_tag_t            : {valid, id} entry of the read-return pipeline
package simd_mem_pkg;

  localparam int unsigned MAX_CH     = 8;
  localparam int unsigned MAX_RD_LAT = 4;

  // $clog2(max(n,2)): a single channel still needs a one-bit index
  function automatic int unsigned ch_id_w(input int unsigned n);
    return (n < 2) ? 32'd1 : 32'($clog2(n));
  endfunction

  localparam int unsigned CH_ID_W = ch_id_w(MAX_CH);

  typedef struct packed {
    logic               valid;
    logic [CH_ID_W-1:0] id;
  } rd_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first asserted request at or above ptr,
// wrapping to channel 0 when none is found above.
//   req    : per-channel request
//   ptr    : current highest-priority channel (always < N)
//   gnt    : one-hot grant, zero when no request
//   gnt_id : index of the granted channel (0 when idle)
module rr_arbiter
  import simd_mem_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]       req,
  input  logic [CH_ID_W-1:0] ptr,
  output logic [N-1:0]       gnt,
  output logic [CH_ID_W-1:0] gnt_id
);

  logic found;

  // Two passes: [ptr, N-1] first, then [0, N-1] catches the wrapped range
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req[i] && (i >= 32'(ptr))) begin
        gnt[i] = 1'b1;
        gnt_id = CH_ID_W'(i);
        found  = 1'b1;
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        gnt[i] = 1'b1;
        gnt_id = CH_ID_W'(i);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/simd_mem_arbiter.sv
// N-channel round-robin arbiter and read-return router in front of one wide
// data-memory port. Grants and RAM drive are combinational from the requests;
// read returns are tagged with the channel id and released RD_LAT edges later.
//   clk, reset                 : clock, asynchronous active-high reset
//   ch_req/ch_we/ch_addr/
//   ch_be/ch_wdata             : packed per-channel request payloads
//   ch_gnt                     : one-hot grant (transfer when req & gnt)
//   ch_rvalid, ch_rdata        : one-hot read-return strobe, broadcast read data
//   address_RAM, byteena_RAM,
//   writeData_RAM, rden_RAM,
//   wren_RAM                   : drive to the data memory
//   readData_RAM               : data memory read data
module simd_mem_arbiter
  import simd_mem_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DATA_W = 256,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned BE_W   = DATA_W / 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH-1:0]        ch_we,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*BE_W-1:0]   ch_be,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
  output logic [NUM_CH-1:0]        ch_gnt,
  output logic [NUM_CH-1:0]        ch_rvalid,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic [ADDR_W-1:0]        address_RAM,
  output logic [BE_W-1:0]          byteena_RAM,
  output logic [DATA_W-1:0]        writeData_RAM,
  output logic                     rden_RAM,
  output logic                     wren_RAM,
  input  logic [DATA_W-1:0]        readData_RAM
);

  logic [NUM_CH-1:0]  arb_gnt;
  logic [CH_ID_W-1:0] arb_id;
  logic [CH_ID_W-1:0] ptr_q;
  logic [CH_ID_W-1:0] ptr_d;
  logic               gnt_any;
  rd_tag_t            tag_q [RD_LAT];
  rd_tag_t            ret_tag;

  rr_arbiter #(
    .N (NUM_CH)
  ) u_rr_arbiter (
    .req    (ch_req),
    .ptr    (ptr_q),
    .gnt    (arb_gnt),
    .gnt_id (arb_id)
  );

  // No grant is issued while reset is held
  assign ch_gnt  = reset ? '0 : arb_gnt;
  assign gnt_any = |ch_gnt;

  // Pointer moves just past the granted channel; held when idle
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = ((32'(arb_id) + 32'd1) >= NUM_CH) ? '0 : arb_id + CH_ID_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Steer the granted channel onto the RAM port; all-zero when idle
  always_comb begin
    address_RAM   = '0;
    byteena_RAM   = '0;
    writeData_RAM = '0;
    rden_RAM      = 1'b0;
    wren_RAM      = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ch_gnt[i]) begin
        address_RAM   = ch_addr[i*ADDR_W +: ADDR_W];
        writeData_RAM = ch_wdata[i*DATA_W +: DATA_W];
        wren_RAM      = ch_we[i];
        rden_RAM      = ~ch_we[i];
        byteena_RAM   = ch_we[i] ? ch_be[i*BE_W +: BE_W] : '1;
      end
    end
  end

  // Read tag pipeline, one stage per RAM latency edge; reset drops in-flight reads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= rd_tag_t'{valid: rden_RAM, id: arb_id};
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign ret_tag = tag_q[RD_LAT-1];

  // Decode the returning tag; read data passes through only while valid
  always_comb begin
    ch_rvalid = '0;
    ch_rdata  = '0;
    if (ret_tag.valid) begin
      ch_rdata = readData_RAM;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (32'(ret_tag.id) == i) begin
          ch_rvalid[i] = 1'b1;
        end
      end
    end
  end

endmodule
